// File: rtl/audio_pkg.sv
// Shared types for the serial audio receiver: bus format selection and
// receiver FSM state encoding.
package audio_pkg;

  typedef enum logic [1:0] {
    MODE_I2S = 2'd0,
    MODE_LJ  = 2'd1,
    MODE_TDM = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_SKIP      = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous first-word-fall-through sample buffer; head is zero while empty.
module audio_sample_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_valid_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o       = (count_q == (AW+1)'(DEPTH));
  assign head_valid_o = (count_q != '0);
  assign do_pop       = pop_i & head_valid_o;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push      = push_i & (~full_o | do_pop);
  assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/serial_audio_receiver.sv
// I2S / left-justified / TDM serial audio receiver. Bit clock is oversampled
// by clk; captured samples are queued with their channel index.
module serial_audio_receiver
  import audio_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  mode_t                   mode,
  input  logic                    clear_errors,
  input  logic                    bck,
  input  logic                    lrck,
  input  logic                    sdata,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic [CW-1:0]           out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    framing_error,
  output state_t                  dbg_state_o
);

  localparam int CNTW = $clog2(SLOT_WIDTH) + 1;
  localparam int FW   = CW + SAMPLE_WIDTH;

  logic bck_s1_q, bck_s2_q, bck_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_last_q;
  logic sdata_s1_q, sdata_s2_q;
  state_t state_q, state_d;
  mode_t  mode_q;
  logic [CW-1:0]           chan_q;
  logic [CNTW-1:0]         bit_cnt_q;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic overflow_q, ferr_q;

  logic bck_rise, is_tdm, lrck_edge, sync_ev, slot_end, last_bit, chan_last;
  logic load_sync, shift_en, cnt_inc, next_slot, push, ferr_set, ovf_set;
  logic fifo_full;
  logic [FW-1:0] fifo_head;

  always_ff @(posedge clk) begin
    if (!reset) begin
      {bck_s1_q, bck_s2_q, bck_s3_q}       <= '0;
      {lrck_s1_q, lrck_s2_q, lrck_last_q}  <= '0;
      {sdata_s1_q, sdata_s2_q}             <= '0;
    end else begin
      {bck_s3_q, bck_s2_q, bck_s1_q} <= {bck_s2_q, bck_s1_q, bck};
      {lrck_s2_q, lrck_s1_q}         <= {lrck_s1_q, lrck};
      {sdata_s2_q, sdata_s1_q}       <= {sdata_s1_q, sdata};
      if (bck_rise) lrck_last_q <= lrck_s2_q;
    end
  end

  assign bck_rise  = bck_s2_q & ~bck_s3_q;
  assign is_tdm    = (mode_q == MODE_TDM);
  // TDM frames start on the rising frame-sync edge only; I2S/LJ slots on either edge.
  assign lrck_edge = is_tdm ? (lrck_s2_q & ~lrck_last_q) : (lrck_s2_q ^ lrck_last_q);
  assign sync_ev   = bck_rise & lrck_edge;
  assign slot_end  = is_tdm & (bit_cnt_q == CNTW'(SLOT_WIDTH - 1));
  assign last_bit  = (bit_cnt_q == CNTW'(SAMPLE_WIDTH - 1));
  assign chan_last = (chan_q == CW'(NUM_CHANNELS - 1));
  assign shift_d   = {shift_q[SAMPLE_WIDTH-2:0], sdata_s2_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_I2S;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) mode_q <= mode;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_WAIT_SYNC;
    end else if (sync_ev) begin
      state_d = (mode_q == MODE_LJ) ? ST_SHIFT : ST_SKIP;
    end else if (bck_rise) begin
      case (state_q)
        ST_SKIP: state_d = ST_SHIFT;
        ST_SHIFT, ST_DONE: begin
          if (slot_end)                               state_d = chan_last ? ST_WAIT_SYNC : ST_SHIFT;
          else if ((state_q == ST_SHIFT) && last_bit) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    load_sync = 1'b0;
    shift_en  = 1'b0;
    cnt_inc   = 1'b0;
    next_slot = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
    if (enable && (state_q != ST_IDLE)) begin
      if (sync_ev) begin
        load_sync = 1'b1;
        ferr_set  = (state_q == ST_SKIP) || (state_q == ST_SHIFT);
      end else if (bck_rise) begin
        if (state_q == ST_SHIFT) begin
          shift_en = 1'b1;
          push     = last_bit;
        end
        if ((state_q == ST_SHIFT) || (state_q == ST_DONE)) begin
          cnt_inc = 1'b1;
          if (slot_end) begin
            next_slot = 1'b1;
            ferr_set  = chan_last;
          end
        end
      end
    end
  end

  // bit_cnt counts bck rises since the slot's first data bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chan_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (load_sync) begin
        chan_q    <= is_tdm ? '0 : CW'(lrck_s2_q);
        bit_cnt_q <= '0;
      end else if (next_slot) begin
        chan_q    <= chan_q + CW'(1);
        bit_cnt_q <= '0;
      end else if (cnt_inc) begin
        bit_cnt_q <= bit_cnt_q + CNTW'(1);
      end
      if (shift_en) shift_q <= shift_d;
    end
  end

  assign ovf_set = push & fifo_full & ~out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      overflow_q <= ovf_set  | (overflow_q & ~clear_errors);
      ferr_q     <= ferr_set | (ferr_q & ~clear_errors);
    end
  end

  audio_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (push),
    .push_data_i  ({chan_q, shift_d}),
    .pop_i        (out_ready),
    .head_data_o  (fifo_head),
    .head_valid_o (out_valid),
    .full_o       (fifo_full)
  );

  assign out_data      = fifo_head[SAMPLE_WIDTH-1:0];
  assign out_chan      = fifo_head[FW-1:SAMPLE_WIDTH];
  assign overflow      = overflow_q;
  assign framing_error = ferr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_serial_audio_receiver.sv
// Bench for serial_audio_receiver: a serial transmitter built from frame
// descriptions, an expected-sample queue and a monitor on the output port.
module tb_serial_audio_receiver;
  import audio_pkg::*;

  localparam int NCH = 8, SW = 24, SLOTW = 32, DEPTH = 16, CW = 3, W = CW + SW;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear_errors = 1'b0;
  logic bck = 1'b0, lrck = 1'b0, sdata = 1'b0, out_ready = 1'b0;
  mode_t mode = MODE_I2S;
  logic [SW-1:0] out_data;
  logic [CW-1:0] out_chan;
  logic          out_valid, overflow, framing_error;
  state_t        dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [1:0]    st_q[$];      // per bck period: {lrck, sdata}
  logic [SW-1:0] slot_v[NCH];
  int n_err = 0, n_chk = 0;
  bit ready_en = 1'b0, hold_pending = 1'b0;
  logic [W-1:0] held;

  serial_audio_receiver #(
    .NUM_CHANNELS (NCH), .SAMPLE_WIDTH (SW), .SLOT_WIDTH (SLOTW), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .reset (rst_n), .enable (enable), .mode (mode),
    .clear_errors (clear_errors), .bck (bck), .lrck (lrck), .sdata (sdata),
    .out_data (out_data), .out_chan (out_chan), .out_valid (out_valid),
    .out_ready (out_ready), .overflow (overflow), .framing_error (framing_error),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] rnd_smp();
    return SW'($urandom());
  endfunction

  // One lrck half (or slot run) of len bck periods; sample MSB at period 'delay'.
  task automatic add_half(input logic lr, input int len, input int delay,
                          input logic [SW-1:0] smp, input bit exp_en);
    for (int i = 0; i < len; i++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      if (i >= delay && i < delay + SW) d = smp[SW-1-(i-delay)];
      st_q.push_back({lr, d});
    end
    if (exp_en) exp_q.push_back({CW'(lr), smp});
  endtask

  // I2S data starts two bck after the lrck edge, LJ one after.
  task automatic add_stereo(input bit lj, input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input bit exp_en);
    add_half(1'b0, SLOTW, lj ? 1 : 2, l, exp_en);
    add_half(1'b1, SLOTW, lj ? 1 : 2, r, exp_en);
  endtask

  // TDM frame: one-bck sync pulse, slot k data from period 2 + k*SLOTW.
  task automatic add_tdm(input bit exp_en);
    for (int i = 0; i < NCH * SLOTW; i++) begin
      logic d;
      int k, j;
      d = 1'($urandom_range(0, 1));
      k = (i - 2) / SLOTW;
      j = (i - 2) % SLOTW;
      if (i >= 2 && j < SW) d = slot_v[k][SW-1-j];
      st_q.push_back({(i == 0) ? 1'b1 : 1'b0, d});
    end
    if (exp_en)
      for (int k = 0; k < NCH; k++) exp_q.push_back({CW'(k), slot_v[k]});
  endtask

  task automatic play();
    logic [1:0] p;
    while (st_q.size() != 0) begin
      p = st_q.pop_front();
      @(negedge clk);
      bck = 1'b0; lrck = p[1]; sdata = p[0];
      repeat (4) @(negedge clk);
      bck = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic start(input mode_t m, input logic pre);
    @(negedge clk);
    enable = 1'b0;
    mode   = m;
    add_half(pre, 3, SLOTW, '0, 1'b0);
    play();
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_errors = 1'b1;
    @(posedge clk); #1 clear_errors = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 out_ready = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: pops the expected queue on every accepted head, checks head stability.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && hold_pending) check("hold", {out_valid, out_chan, out_data}, {1'b1, held});
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: got chan %0d data %0h expected none", out_chan, out_data);
        end else begin
          e = exp_q.pop_front();
          check("sample", {out_chan, out_data}, e);
        end
        hold_pending = 1'b0;
      end else if (rst_n && out_valid) begin
        hold_pending = 1'b1;
        held = {out_chan, out_data};
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    #3ms;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    mode_t m;
    int nfr;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_state", dbg_state, ST_IDLE);
    ready_en = 1'b1;

    // I2S stereo frame with fixed samples
    start(MODE_I2S, 1'b1);
    add_stereo(1'b0, 24'h123456, 24'hABCDEF, 1'b1);
    play();
    wait_drain("i2s_drain");
    check("i2s_ferr", framing_error, 0);
    check("i2s_ovf", overflow, 0);

    // TDM, two identical frames of slots 1..8
    start(MODE_TDM, 1'b0);
    for (int k = 0; k < NCH; k++) slot_v[k] = SW'(k + 1);
    add_tdm(1'b1);
    add_tdm(1'b1);
    play();
    wait_drain("tdm_drain");
    check("tdm_ferr", framing_error, 0);

    // I2S left word cut short after 10 bits
    start(MODE_I2S, 1'b1);
    add_half(1'b0, 12, 2, rnd_smp(), 1'b0);
    add_half(1'b1, SLOTW, 2, rnd_smp(), 1'b1);
    add_stereo(1'b0, rnd_smp(), rnd_smp(), 1'b1);
    play();
    wait_drain("short_drain");
    check("short_ferr_set", framing_error, 1);
    pulse_clear();
    check("short_ferr_clr", framing_error, 0);

    // TDM frame sync withheld after slot 7, then resync
    start(MODE_TDM, 1'b0);
    for (int k = 0; k < NCH; k++) slot_v[k] = rnd_smp();
    add_tdm(1'b1);
    add_half(1'b0, 12, SLOTW, '0, 1'b0);
    play();
    check("nosync_state", dbg_state, ST_WAIT_SYNC);
    check("nosync_ferr", framing_error, 1);
    for (int k = 0; k < NCH; k++) slot_v[k] = rnd_smp();
    add_tdm(1'b1);
    play();
    wait_drain("resync_drain");

    // LJ with consumer stalled for 20 frames: only the first 16 samples survive
    ready_en = 1'b0;
    start(MODE_LJ, 1'b1);
    for (int f = 0; f < 20; f++) add_stereo(1'b1, rnd_smp(), rnd_smp(), f < DEPTH / 2);
    play();
    check("ovf_valid", out_valid, 1);
    check("ovf_flag", overflow, 1);
    ready_en = 1'b1;
    wait_drain("ovf_drain");
    repeat (20) @(negedge clk);
    check("ovf_empty", out_valid, 0);

    // Reset in the middle of a slot with three samples queued
    ready_en = 1'b0;
    start(MODE_I2S, 1'b1);
    add_stereo(1'b0, rnd_smp(), rnd_smp(), 1'b1);
    add_half(1'b0, SLOTW, 2, rnd_smp(), 1'b1);
    add_half(1'b1, 10, 2, rnd_smp(), 1'b0);
    play();
    check("mid_state", dbg_state, ST_SHIFT);
    check("mid_valid", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_ferr", framing_error, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    ready_en = 1'b1;
    start(MODE_I2S, 1'b1);
    add_stereo(1'b0, rnd_smp(), rnd_smp(), 1'b1);
    add_stereo(1'b0, rnd_smp(), rnd_smp(), 1'b1);
    play();
    wait_drain("post_rst_drain");

    // Random modes; mode input is changed after enable and must be ignored
    for (int r = 0; r < 5; r++) begin
      m = mode_t'($urandom_range(0, 2));
      start(m, (m == MODE_TDM) ? 1'b0 : 1'b1);
      mode = mode_t'((int'(m) + 1) % 3);
      if (m == MODE_TDM) begin
        for (int k = 0; k < NCH; k++) slot_v[k] = rnd_smp();
        add_tdm(1'b1);
      end else begin
        nfr = $urandom_range(1, 3);
        for (int f = 0; f < nfr; f++) add_stereo(m == MODE_LJ, rnd_smp(), rnd_smp(), 1'b1);
      end
      play();
      wait_drain("rand_drain");
      check("rand_ferr", framing_error, 0);
      check("rand_ovf", overflow, 0);
    end

    enable = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
